// File: rtl/seq_header_parser_v2.sv
// AV1 sequence OBU front-end parser: OBU header, LEB128 size, operating points and
// frame dimensions, read from an MSB-first bit window with per-cycle consume control.
module seq_header_parser_v2 #(
  parameter int unsigned  DATA_W  = 64,
  parameter int unsigned  MAX_OPS = 32,
  localparam int unsigned LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              avail,
  input  logic              start,
  output logic              consume,
  output logic [LEN_W-1:0]  consume_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [55:0]       obu_size,
  output logic [2:0]        seq_profile,
  output logic              still_picture,
  output logic              reduced_still,
  output logic [5:0]        op_cnt,
  output logic [4:0]        seq_level_idx0,
  output logic              seq_tier0,
  output logic [4:0]        frame_width_bits,
  output logic [4:0]        frame_height_bits,
  output logic [15:0]       max_width_m1,
  output logic [15:0]       max_height_m1
);

  localparam int unsigned WIN_W  = 64;
  localparam int unsigned SIZE_W = 56;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEB, S_SEQ, S_OPS, S_DIMS, S_WIDTH, S_HEIGHT
  } state_t;

  state_t           state;
  logic [2:0]       err_code_q;
  logic [5:0]       op_idx;
  logic             idp_q;
  logic [WIN_W-1:0] win;

  assign win = data_in[DATA_W-1 -: WIN_W];

  // LEB128: first byte with a clear continuation bit terminates the field
  logic [3:0]        leb_n;
  logic              leb_found;
  logic [SIZE_W-1:0] leb_val;

  always_comb begin
    leb_n     = '0;
    leb_found = 1'b0;
    leb_val   = '0;
    for (int i = 0; i < 8; i++) begin
      if (!leb_found) begin
        leb_val = leb_val | (SIZE_W'(win[62-8*i -: 7]) << (7 * i));
        if (!win[63-8*i]) begin
          leb_found = 1'b1;
          leb_n     = 4'(i + 1);
        end
      end
    end
  end

  // Operating point: idc(12) level(5) [tier if level>7] [present [delay(4)] if idp]
  logic [4:0] op_level;
  logic       op_gt7;
  logic       op_tier;
  logic       op_present;
  logic [4:0] op_len;

  assign op_level   = win[51:47];
  assign op_gt7     = (op_level > 5'd7);
  assign op_tier    = op_gt7 & win[46];
  assign op_present = op_gt7 ? win[45] : win[46];
  assign op_len     = 5'd17 + 5'(op_gt7) + 5'(idp_q) + ((idp_q && op_present) ? 5'd4 : 5'd0);

  logic        ops_too_many;
  logic [15:0] field_w;
  logic [15:0] field_h;

  assign ops_too_many = ((6'(win[56:52]) + 6'd1) > 6'(MAX_OPS));
  assign field_w      = win[63:48] >> (5'd16 - frame_width_bits);
  assign field_h      = win[63:48] >> (5'd16 - frame_height_bits);

  // Per-state step decode: bits to drop, or abort with a cause
  logic [LEN_W-1:0] step_len;
  logic             step_abort;
  logic [2:0]       step_code;

  always_comb begin
    step_len   = '0;
    step_abort = 1'b0;
    step_code  = 3'd0;
    case (state)
      S_HDR: begin
        if (win[63] || (win[62:59] != 4'd1)) begin
          step_abort = 1'b1;
          step_code  = 3'd1;
        end else if (!win[57]) begin
          step_abort = 1'b1;
          step_code  = 3'd2;
        end else begin
          step_len = win[58] ? LEN_W'(16) : LEN_W'(8);
        end
      end
      S_LEB: begin
        if (!leb_found) begin
          step_abort = 1'b1;
          step_code  = 3'd4;
        end else begin
          step_len = LEN_W'({leb_n, 3'b000});
        end
      end
      S_SEQ: begin
        if (win[59]) begin
          step_len = LEN_W'(10);
        end else if (win[58] || ops_too_many) begin
          step_abort = 1'b1;
          step_code  = 3'd3;
        end else begin
          step_len = LEN_W'(12);
        end
      end
      S_OPS:    step_len = LEN_W'(op_len);
      S_DIMS:   step_len = LEN_W'(8);
      S_WIDTH:  step_len = LEN_W'(frame_width_bits);
      S_HEIGHT: step_len = LEN_W'(frame_height_bits);
      default:  ;
    endcase
  end

  logic take;

  assign take        = avail && !rst && (state != S_IDLE);
  assign consume     = take && !step_abort;
  assign consume_len = consume ? step_len : '0;
  assign done        = take && (state == S_HEIGHT);
  assign error       = take && step_abort;
  assign err_code    = error ? step_code : err_code_q;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      state             <= rst ? S_IDLE : S_HDR;
      err_code_q        <= '0;
      op_idx            <= '0;
      idp_q             <= 1'b0;
      obu_size          <= '0;
      seq_profile       <= '0;
      still_picture     <= 1'b0;
      reduced_still     <= 1'b0;
      op_cnt            <= '0;
      seq_level_idx0    <= '0;
      seq_tier0         <= 1'b0;
      frame_width_bits  <= '0;
      frame_height_bits <= '0;
      max_width_m1      <= '0;
      max_height_m1     <= '0;
    end else if (state != S_IDLE && avail) begin
      if (step_abort) begin
        state      <= S_IDLE;
        err_code_q <= step_code;
      end else begin
        case (state)
          S_HDR: state <= S_LEB;
          S_LEB: begin
            obu_size <= leb_val;
            state    <= S_SEQ;
          end
          S_SEQ: begin
            seq_profile   <= win[63:61];
            still_picture <= win[60];
            reduced_still <= win[59];
            if (win[59]) begin
              op_cnt         <= 6'd1;
              seq_level_idx0 <= win[58:54];
              seq_tier0      <= 1'b0;
              state          <= S_DIMS;
            end else begin
              op_cnt <= 6'(win[56:52]) + 6'd1;
              idp_q  <= win[57];
              op_idx <= '0;
              state  <= S_OPS;
            end
          end
          S_OPS: begin
            if (op_idx == 6'd0) begin
              seq_level_idx0 <= op_level;
              seq_tier0      <= op_tier;
            end
            op_idx <= op_idx + 6'd1;
            if ((op_idx + 6'd1) == op_cnt) state <= S_DIMS;
          end
          S_DIMS: begin
            frame_width_bits  <= 5'(win[63:60]) + 5'd1;
            frame_height_bits <= 5'(win[59:56]) + 5'd1;
            state             <= S_WIDTH;
          end
          S_WIDTH: begin
            max_width_m1 <= field_w;
            state        <= S_HEIGHT;
          end
          S_HEIGHT: begin
            max_height_m1 <= field_h;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
